// File: rtl/gouram_trace_pkg.sv
// rtl/gouram_trace_pkg.sv - shared trace record widths, serializer state and beat selection
package gouram_trace_pkg;

   localparam int BEAT_WIDTH       = 32;
   localparam int BEATS_PER_RECORD = 5;
   localparam int RECORD_WIDTH     = 160;
   localparam int BEAT_IDX_WIDTH   = 3;
   localparam logic [BEAT_IDX_WIDTH-1:0] LAST_BEAT = 3'(BEATS_PER_RECORD - 1);

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

   // Record layout is {timestamp, data[127:0]}; the timestamp goes out first.
   function automatic logic [BEAT_WIDTH-1:0] record_beat(
      input logic [RECORD_WIDTH-1:0]   rec,
      input logic [BEAT_IDX_WIDTH-1:0] idx
   );
      logic [BEAT_WIDTH-1:0] beat;
      case (idx)
         3'd0:    beat = rec[159:128];
         3'd1:    beat = rec[31:0];
         3'd2:    beat = rec[63:32];
         3'd3:    beat = rec[95:64];
         3'd4:    beat = rec[127:96];
         default: beat = '0;
      endcase
      return beat;
   endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// rtl/trace_record_fifo.sv - record FIFO with registered read data and full/empty/count flags
module trace_record_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 160
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      rd_ptr_next;

   assign rd_ptr_next = rd_en ? rd_ptr + PTR_ONE : rd_ptr;
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count       = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Read data tracks the next head; a write landing on that slot is forwarded so
   // a record written into an empty (or just-drained) FIFO is visible next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         rd_ptr <= rd_ptr_next;
         if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
            rd_data <= wr_data;
         end else begin
            rd_data <= mem[rd_ptr_next[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/trace_record_drain.sv
// rtl/trace_record_drain.sv - buffers timestamped trace records and drains them as 32-bit beats
module trace_record_drain
   import gouram_trace_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [127:0]                  trace_data_i,
   input  logic                          trace_capture_enable_i,
   input  logic                          lock_i,
   input  logic [31:0]                   counter_i,
   output logic [BEAT_WIDTH-1:0]         m_data_o,
   output logic                          m_valid_o,
   output logic                          m_last_o,
   input  logic                          m_ready_i,
   output logic                          overflow_o,
   output logic [DROP_CNT_WIDTH-1:0]     dropped_count_o,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   ser_state_e                state_q, state_d;
   logic [BEAT_IDX_WIDTH-1:0] beat_q, beat_d;

   logic                      capture_req, can_write, wr_en, pop, drop;
   logic                      fifo_full, fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic [RECORD_WIDTH-1:0]   rd_data;

   assign capture_req = trace_capture_enable_i && !lock_i;
   assign pop         = (state_q == SER_SEND) && (beat_q == LAST_BEAT) && m_ready_i;
   assign can_write   = !fifo_full || pop;
   assign wr_en       = capture_req && can_write;
   assign drop        = capture_req && !can_write;

   trace_record_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RECORD_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data ({counter_i, trace_data_i}),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign fill_level_o = fifo_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SER_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // On the final beat, a record written in the same cycle counts as remaining.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         SER_IDLE: begin
            if (!fifo_empty) begin
               state_d = SER_SEND;
               beat_d  = '0;
            end
         end
         SER_SEND: begin
            if (m_ready_i) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = (fifo_count > CNT_W'(1) || wr_en) ? SER_SEND : SER_IDLE;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = SER_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   always_comb begin
      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      m_data_o  = '0;
      if (state_q == SER_SEND) begin
         m_valid_o = 1'b1;
         m_last_o  = (beat_q == LAST_BEAT);
         m_data_o  = record_beat(rd_data, beat_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_o      <= 1'b0;
         dropped_count_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (dropped_count_o != {DROP_CNT_WIDTH{1'b1}}) begin
            dropped_count_o <= dropped_count_o + 1'b1;
         end
      end
   end

endmodule

// File: doc/trace_record_drain.md
TRACE_RECORD_DRAIN -- requirements
Module: trace_record_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered trace records (power of two, at least 2).
REQ-002 SHALL have parameter DROP_CNT_WIDTH, default 16, width of the dropped-record counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port trace_data_i  input  128  trace record from the tracer.
REQ-006 SHALL have port trace_capture_enable_i  input  1  record-valid strobe, one record per high cycle.
REQ-007 SHALL have port lock_i  input  1  tracer lock; while high, captures are ignored.
REQ-008 SHALL have port counter_i  input  32  tracer cycle counter, used as the record timestamp.
REQ-009 SHALL have port m_data_o  output  32  output stream beat.
REQ-010 SHALL have port m_valid_o  output  1  beat valid.
REQ-011 SHALL have port m_last_o  output  1  final beat of a record.
REQ-012 SHALL have port m_ready_i  input  1  downstream accepts the beat.
REQ-013 SHALL have port overflow_o  output  1  sticky flag: at least one record was dropped.
REQ-014 SHALL have port dropped_count_o  output  DROP_CNT_WIDTH  number of dropped records.
REQ-015 SHALL have port fill_level_o  output  $clog2(FIFO_DEPTH)+1  number of records held in the FIFO.

Function
REQ-016 SHALL capture {counter_i, trace_data_i} as one 160-bit record on each cycle where trace_capture_enable_i=1, lock_i=0 and the FIFO can accept a write.
REQ-017 SHALL treat the FIFO as able to accept a write when it is not full, or when it is full and the record in the serializer is popped in the same cycle.
REQ-018 SHALL, when a capture is attempted and the FIFO cannot accept it, discard the record, set overflow_o, and increment dropped_count_o, saturating at all-ones.
REQ-019 SHALL neither capture nor count as dropped any strobe that occurs while lock_i=1.
REQ-020 SHALL serialize each record as 5 beats: beat0=timestamp, beat1=data[31:0], beat2=data[63:32], beat3=data[95:64], beat4=data[127:96]; m_last_o=1 on beat4 only.
REQ-021 SHALL implement the serializer state machine as IDLE and SEND, with a beat index 0..4.
REQ-022 SHALL move IDLE->SEND when the FIFO is non-empty, with beat index 0.
REQ-023 SHALL advance the beat index in SEND on each cycle where m_valid_o and m_ready_i are both 1.
REQ-024 SHALL, when beat4 is accepted, pop the record, then go to SEND at beat 0 if another record remains, otherwise to IDLE (back-to-back records with no bubble).
REQ-025 SHALL drive m_valid_o=1 exactly when in SEND.
REQ-026 SHALL hold m_data_o and m_last_o stable while m_valid_o=1 and m_ready_i=0, and SHALL NOT deassert m_valid_o before the beat is accepted.
REQ-027 SHALL give a latency of 1 cycle: a record captured at edge N into an empty FIFO makes m_valid_o=1 after edge N+1 (registered FIFO read, no combinational path from trace inputs to the m_* outputs).
REQ-028 SHALL make fill_level_o count records held in the FIFO, including the record being serialized, and update it on simultaneous write and pop so it is unchanged.
REQ-029 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, distinguishing full from empty with an extra pointer bit.

Reset
REQ-030 SHALL, while rst=1, asynchronously clear m_valid_o, m_last_o, m_data_o, overflow_o, dropped_count_o and fill_level_o to 0, and set the state to IDLE with beat index 0.
REQ-031 SHALL, on reset mid-record, abandon the partial record; after release, output resumes only with newly captured records.
REQ-032 SHALL clear overflow_o only by reset.

Structure
REQ-033 SHALL place BEAT_WIDTH=32, BEATS_PER_RECORD=5, RECORD_WIDTH=160 and the serializer state enum in the shared package gouram_trace_pkg.
REQ-034 SHALL implement the record FIFO as sub-module trace_record_fifo (synchronous, one clock, registered read data, full/empty/count outputs).

Verification
REQ-035 SHALL cover single record: lock_i=0, one strobe with data=0x0000_0004_0000_0003_0000_0002_0000_0001 and counter=0x10, m_ready_i=1 -> beats 0x10,1,2,3,4, with m_last_o only on 4 and m_valid_o rising 1 cycle after capture.
REQ-036 SHALL cover backpressure: m_ready_i toggling 1/0 every cycle -> every beat held stable while stalled, 5 beats per record, order unchanged.
REQ-037 SHALL cover overflow: FIFO_DEPTH=8, m_ready_i=0, 10 strobes -> fill_level_o=8, dropped_count_o=2, overflow_o=1; after m_ready_i=1, exactly 40 beats are emitted.
REQ-038 SHALL cover full with simultaneous pop: strobe in the same cycle beat4 of the head record is accepted -> the record is captured, dropped_count_o is unchanged and fill_level_o is unchanged.
REQ-039 SHALL cover lock: 3 strobes with lock_i=1 -> no beats, dropped_count_o=0, fill_level_o=0.
REQ-040 SHALL cover reset mid-record: rst pulsed after beat2 is accepted -> all outputs are 0 and the next record starts at beat0.
